dmem_arbiter: RTL

//  Shares the single-port data memory (64-bit words, word-indexed, Size entries) between two requesters:

---
 rtl/dmem_arb_pkg.sv | 31 +++
 rtl/dmem_arb_grant.sv | 47 ++++
 rtl/dmem_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Port 0 is the core LSU, port 1 is the loader/debug port.
package dmem_arb_pkg;
  localparam int XLEN = 64;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic id;
    logic we;
    logic err;
  } txn_t;

  // Full-width compare so huge addresses cannot alias into range.
  function automatic logic addr_oob(input logic [XLEN-1:0] a, input int depth);
    return a >= XLEN'(depth);
  endfunction
endpackage

// File: rtl/dmem_arb_grant.sv
// Two-way round-robin pick with a starvation guard for port 1.
// State advances only when the top actually accepts the granted request.
module dmem_arb_grant
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_rr_off,
  input  logic i_take,
  output logic o_gnt_id,
  output logic o_gnt_vld
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  logic          r_last;
  logic [CW-1:0] r_wait_cnt;
  logic          w_force;

  assign w_force   = (r_wait_cnt == CNT_MAX);
  assign o_gnt_vld = i_req0 | i_req1;

  always_comb begin
    o_gnt_id = PORT_CORE;
    if (i_req0 && i_req1)
      o_gnt_id = w_force ? PORT_DBG : (i_rr_off ? PORT_CORE : ~r_last);
    else if (i_req1)
      o_gnt_id = PORT_DBG;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= PORT_DBG;
      r_wait_cnt <= '0;
    end else if (i_take && o_gnt_vld) begin
      r_last <= o_gnt_id;
      if (o_gnt_id == PORT_DBG)
        r_wait_cnt <= '0;
      else if (i_req1 && !w_force)
        r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Single-transaction arbiter in front of the data memory: accept, one memory
// cycle, one response cycle. Accepting again in RESP gives one access per 2 cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            test_rr_off,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_we,
  input  logic [XLEN-1:0] req0_addr,
  input  logic [XLEN-1:0] req0_wdata,
  output logic            rsp0_valid,
  output logic [XLEN-1:0] rsp0_rdata,
  output logic            rsp0_err,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_we,
  input  logic [XLEN-1:0] req1_addr,
  input  logic [XLEN-1:0] req1_wdata,
  output logic            rsp1_valid,
  output logic [XLEN-1:0] rsp1_rdata,
  output logic            rsp1_err,
  output logic            mem_rw,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);
  arb_state_e      r_state;
  txn_t            r_txn;
  req_t            w_req0, w_req1, w_sel;
  logic            w_gnt_id, w_gnt_vld, w_open, w_take, w_sel_err;
  logic [XLEN-1:0] w_rd;

  dmem_arb_grant #(.MAX_WAIT(MAX_WAIT)) u_grant (
    .clk       (clk),
    .rst       (rst),
    .i_req0    (req0_valid),
    .i_req1    (req1_valid),
    .i_rr_off  (test_rr_off),
    .i_take    (w_take),
    .o_gnt_id  (w_gnt_id),
    .o_gnt_vld (w_gnt_vld)
  );

  // Reset masks ready so nothing is ever accepted while rst is high.
  assign w_open     = ((r_state == ST_IDLE) || (r_state == ST_RESP)) && !rst;
  assign w_take     = w_open && w_gnt_vld;
  assign req0_ready = w_take && (w_gnt_id == PORT_CORE);
  assign req1_ready = w_take && (w_gnt_id == PORT_DBG);

  assign w_req0    = '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
  assign w_req1    = '{we: req1_we, addr: req1_addr, wdata: req1_wdata};
  assign w_sel     = (w_gnt_id == PORT_DBG) ? w_req1 : w_req0;
  assign w_sel_err = addr_oob(w_sel.addr, DEPTH);
  assign w_rd      = (r_txn.we || r_txn.err) ? '0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_txn      <= '0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      mem_rw     <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_take) begin
            r_txn     <= '{id: w_gnt_id, we: w_sel.we, err: w_sel_err};
            mem_addr  <= w_sel.addr;
            mem_wdata <= w_sel.wdata;
            mem_rw    <= w_sel.we & ~w_sel_err;
            r_state   <= ST_ACCESS;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // Memory read data is combinational, so it is valid at the end of ACCESS.
          if (r_txn.id == PORT_CORE) begin
            rsp0_valid <= 1'b1;
            rsp0_rdata <= w_rd;
            rsp0_err   <= r_txn.err;
          end else begin
            rsp1_valid <= 1'b1;
            rsp1_rdata <= w_rd;
            rsp1_err   <= r_txn.err;
          end
          r_state <= ST_RESP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
